exe_mem_stage_buf: RTL and testbench

Parametrised EX→MEM pipeline boundary that replaces the fixed-field stall register with an elastic valid/ready stage. It carries a control vector (write-back and memory enables, destination) and a data vector (ALU result, store data, PC, immediate) as opaque buses. It supports selectable registered-ready skid buffering, synchronous flush to a bubble, and forcing of control bits to zero whenever the output is not valid.

---
 rtl/exe_mem_stage_buf_pkg.sv | 25 ++
 rtl/exe_mem_stage_buf_entry.sv | 32 +++
 rtl/exe_mem_stage_buf.sv | 130 +++++++++++++
 tb/tb_exe_mem_stage_buf.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/exe_mem_stage_buf_pkg.sv
// Shared EX/MEM boundary definitions: control-bit layout, data field offsets
// and the skid-buffer state encoding.
package exe_mem_stage_buf_pkg;

    localparam int EXM_CTRL_W = 8;

    localparam int WB_EN    = 0;
    localparam int MEM_R_EN = 1;
    localparam int MEM_W_EN = 2;
    localparam int DEST_LSB = 3;
    localparam int DEST_MSB = 7;

    localparam int FIELD_W   = 32;
    localparam int ALU_LSB   = 0;
    localparam int STORE_LSB = 32;
    localparam int PC_LSB    = 64;
    localparam int IMM_LSB   = 96;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/exe_mem_stage_buf_entry.sv
// One pipeline register entry: ctrl+data storage with load enable and a
// synchronous valid clear. Load wins over clear.
module pipe_entry #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            q_ctrl <= '0;
            q_data <= '0;
        end else if (load) begin
            valid  <= 1'b1;
            q_ctrl <= d_ctrl;
            q_data <= d_data;
        end else if (clear) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/exe_mem_stage_buf.sv
// Elastic EX->MEM boundary: valid/ready stage with optional registered-ready
// skid buffer, synchronous flush and control masking on bubbles.
module exe_mem_stage_buf
    import exe_mem_stage_buf_pkg::*;
#(
    parameter int CTRL_W = EXM_CTRL_W,
    parameter int DATA_W = 128,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              in_xfer, out_xfer;
    logic              main_load, main_clear, main_valid;
    logic [CTRL_W-1:0] main_d_ctrl, main_ctrl;
    logic [DATA_W-1:0] main_d_data;

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign out_valid = main_valid;
    // Bubbles never present enables downstream, even if main still holds old bits.
    assign out_ctrl  = main_valid ? main_ctrl : '0;

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load),
        .clear  (main_clear),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .valid  (main_valid),
        .q_ctrl (main_ctrl),
        .q_data (out_data)
    );

    generate
        if (SKID) begin : g_skid
            buf_state_t        state, state_nxt;
            logic              skid_load, skid_clear, skid_valid, main_from_skid;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;

            pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk    (clk),
                .rst    (rst),
                .load   (skid_load),
                .clear  (skid_clear),
                .d_ctrl (in_ctrl),
                .d_data (in_data),
                .valid  (skid_valid),
                .q_ctrl (skid_ctrl),
                .q_data (skid_data)
            );

            always_ff @(posedge clk) begin
                if (rst) state <= EMPTY;
                else     state <= state_nxt;
            end

            always_comb begin
                state_nxt = state;
                if (flush) begin
                    state_nxt = EMPTY;
                end else begin
                    case (state)
                        EMPTY:   if (in_xfer) state_nxt = ONE;
                        ONE: begin
                            if (in_xfer && !out_xfer)      state_nxt = FULL;
                            else if (!in_xfer && out_xfer) state_nxt = EMPTY;
                        end
                        FULL:    if (out_xfer) state_nxt = ONE;
                        default: state_nxt = EMPTY;
                    endcase
                end
            end

            always_comb begin
                main_load      = 1'b0;
                main_clear     = 1'b0;
                main_from_skid = 1'b0;
                skid_load      = 1'b0;
                skid_clear     = 1'b0;
                if (flush) begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end else begin
                    case (state)
                        EMPTY: main_load = in_xfer;
                        ONE: begin
                            main_load  = in_xfer & out_xfer;
                            skid_load  = in_xfer & ~out_xfer;
                            main_clear = out_xfer & ~in_xfer;
                        end
                        FULL: begin
                            main_load      = out_xfer;
                            main_from_skid = 1'b1;
                            skid_clear     = out_xfer;
                        end
                        default: main_clear = 1'b1;
                    endcase
                end
            end

            assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
            assign main_d_data = main_from_skid ? skid_data : in_data;
            // Decoded from registered state only: no path from out_ready.
            assign in_ready    = (state != FULL);
            assign occupancy   = {1'b0, main_valid} + {1'b0, skid_valid};
        end else begin : g_single
            assign in_ready    = ~main_valid | out_ready;
            assign main_load   = in_xfer & ~flush;
            assign main_clear  = flush | (out_xfer & ~in_xfer);
            assign main_d_ctrl = in_ctrl;
            assign main_d_data = in_data;
            assign occupancy   = {1'b0, main_valid};
        end
    endgenerate

endmodule

// File: tb/tb_exe_mem_stage_buf.sv
// Directed bench for exe_mem_stage_buf: skid-mode vector table plus a
// hand-written legacy (SKID=0) stall sequence.
module tb_exe_mem_stage_buf;

    localparam int CW = 8;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst;

    logic          s_flush, s_iv, s_ir, s_ov, s_or;
    logic [CW-1:0] s_ictrl, s_octrl;
    logic [DW-1:0] s_idata, s_odata;
    logic [1:0]    s_occ;

    logic          l_flush, l_iv, l_ir, l_ov, l_or;
    logic [CW-1:0] l_ictrl, l_octrl;
    logic [DW-1:0] l_idata, l_odata;
    logic [1:0]    l_occ;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exe_mem_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) u_skid (
        .clk(clk), .rst(rst), .flush(s_flush),
        .in_valid(s_iv), .in_ready(s_ir), .in_ctrl(s_ictrl), .in_data(s_idata),
        .out_valid(s_ov), .out_ready(s_or), .out_ctrl(s_octrl), .out_data(s_odata),
        .occupancy(s_occ)
    );

    exe_mem_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) u_leg (
        .clk(clk), .rst(rst), .flush(l_flush),
        .in_valid(l_iv), .in_ready(l_ir), .in_ctrl(l_ictrl), .in_data(l_idata),
        .out_valid(l_ov), .out_ready(l_or), .out_ctrl(l_octrl), .out_data(l_odata),
        .occupancy(l_occ)
    );

    typedef struct {
        logic        iv;
        logic        fl;
        logic        ordy;
        logic [31:0] d;
        logic        eov;
        logic [31:0] edat;
        logic [1:0]  eocc;
        logic        eir;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iv, logic fl, logic ordy, logic [31:0] d,
                                logic eov, logic [31:0] edat, logic [1:0] eocc, logic eir);
        vec_t v;
        v.iv = iv; v.fl = fl; v.ordy = ordy; v.d = d;
        v.eov = eov; v.edat = edat; v.eocc = eocc; v.eir = eir;
        return v;
    endfunction

    function automatic logic [CW-1:0] ctrl_of(logic [31:0] d);
        return {1'b1, d[6:0]};
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        s_flush = 1'b0; s_iv = 1'b1; s_ictrl = 8'hFF; s_idata = '1; s_or = 1'b0;
        l_flush = 1'b0; l_iv = 1'b1; l_ictrl = 8'hFF; l_idata = '1; l_or = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        s_iv = 1'b0;
        l_iv = 1'b0; l_or = 1'b1;
        #1;
        chk("rst_ov",   s_ov,    1'b0);
        chk("rst_ctrl", s_octrl, 8'h00);
        chk("rst_occ",  s_occ,   2'd0);
        chk("rst_ir",   s_ir,    1'b1);
        chk("rst_data", s_odata, 128'h0);
        chk("rst_l_ov", l_ov,    1'b0);

        // streaming: in_valid=1, out_ready=1, beats 1..8
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(1, 0, 1, i, 1, i, 2'd1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 2'd0, 1));
        // backpressure: three offers into a stalled MEM
        vecs.push_back(mk(1, 0, 0, 11, 1, 11, 2'd1, 1));
        vecs.push_back(mk(1, 0, 0, 12, 1, 11, 2'd2, 0));
        vecs.push_back(mk(1, 0, 0, 13, 1, 11, 2'd2, 0));
        vecs.push_back(mk(1, 0, 1, 13, 1, 12, 2'd1, 1));
        vecs.push_back(mk(1, 0, 1, 13, 1, 13, 2'd1, 1));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0,  2'd0, 1));
        // flush while full with an incoming beat
        vecs.push_back(mk(1, 0, 0, 31, 1, 31, 2'd1, 1));
        vecs.push_back(mk(1, 0, 0, 32, 1, 31, 2'd2, 0));
        vecs.push_back(mk(1, 1, 0, 33, 0, 0,  2'd0, 1));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0,  2'd0, 1));
        // flush discards a beat accepted in the same cycle
        vecs.push_back(mk(1, 0, 1, 41, 1, 41, 2'd1, 1));
        vecs.push_back(mk(1, 1, 1, 42, 0, 0,  2'd0, 1));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0,  2'd0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            s_iv    = vecs[i].iv;
            s_flush = vecs[i].fl;
            s_or    = vecs[i].ordy;
            s_idata = {96'h0, vecs[i].d};
            s_ictrl = ctrl_of(vecs[i].d);
            tick;
            chk($sformatf("v%0d_ov", i),   s_ov,  vecs[i].eov);
            chk($sformatf("v%0d_ctrl", i), s_octrl, vecs[i].eov ? ctrl_of(vecs[i].edat) : 8'h00);
            chk($sformatf("v%0d_occ", i),  s_occ, vecs[i].eocc);
            chk($sformatf("v%0d_ir", i),   s_ir,  vecs[i].eir);
            if (vecs[i].eov)
                chk($sformatf("v%0d_data", i), s_odata, {96'h0, vecs[i].edat});
        end
        s_iv = 1'b0; s_flush = 1'b0;

        // legacy single-register mode: stall with combinational in_ready
        l_iv = 1'b1; l_idata = {96'h0, 32'hDEAD_BEEF}; l_ictrl = 8'h5A; l_or = 1'b1;
        #1;
        chk("leg_ir_empty", l_ir, 1'b1);
        tick;
        chk("leg_ov_a",   l_ov,    1'b1);
        chk("leg_data_a", l_odata, {96'h0, 32'hDEAD_BEEF});
        chk("leg_occ_a",  l_occ,   2'd1);
        l_idata = {96'h0, 32'h0000_1111}; l_ictrl = 8'h33; l_or = 1'b0;
        #1;
        chk("leg_ir_stall", l_ir, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick;
            chk($sformatf("leg_hold%0d_data", k), l_odata, {96'h0, 32'hDEAD_BEEF});
            chk($sformatf("leg_hold%0d_ctrl", k), l_octrl, 8'h5A);
            chk($sformatf("leg_hold%0d_ir", k),   l_ir,    1'b0);
        end
        l_or = 1'b1;
        #1;
        chk("leg_ir_release", l_ir, 1'b1);
        tick;
        chk("leg_data_b", l_odata, {96'h0, 32'h0000_1111});
        chk("leg_ctrl_b", l_octrl, 8'h33);
        chk("leg_occ_b",  l_occ,   2'd1);
        l_iv = 1'b0;
        tick;
        chk("mask_ov",   l_ov,    1'b0);
        chk("mask_ctrl", l_octrl, 8'h00);
        chk("mask_data", l_odata, {96'h0, 32'h0000_1111});
        chk("mask_occ",  l_occ,   2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
